// File: rtl/vga_timing_pkg.sv
// VGA 640x480@60 timing constants shared by the timing receiver and the colour-bar generator,
// plus the receiver's lock FSM state type.
package vga_timing_pkg;

    localparam int unsigned VGA_H_TOTAL     = 800;
    localparam int unsigned VGA_H_SYNC      = 96;
    localparam int unsigned VGA_H_ACT_START = 144;
    localparam int unsigned VGA_H_ACT_END   = 783;
    localparam int unsigned VGA_V_TOTAL     = 525;
    localparam int unsigned VGA_V_SYNC      = 2;
    localparam int unsigned VGA_V_ACT_START = 35;
    localparam int unsigned VGA_V_ACT_END   = 514;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/vga_timing_rx_sync_edge_det.sv
// Registered edge detector for an active-low sync line; history idles high so a line
// already low when reset is released still produces a fall.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b1;
        else     prev <= sig;
    end

    assign rise = ~prev & sig;
    assign fall = prev & ~sig;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures HSync/VSync against the nominal raster, locks after one
// clean frame, and emits active-pixel strobe, coordinates and gated colour.
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_ACT_START = VGA_H_ACT_START,
    parameter int unsigned H_ACT_END   = VGA_H_ACT_END,
    parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_ACT_START = VGA_V_ACT_START,
    parameter int unsigned V_ACT_END   = VGA_V_ACT_END
) (
    input  logic       pixClock,
    input  logic       reset,
    input  logic       HSync,
    input  logic       VSync,
    input  logic [3:0] red,
    input  logic [3:0] green,
    input  logic [3:0] blue,
    output logic       locked,
    output logic       de,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic [3:0] pix_r,
    output logic [3:0] pix_g,
    output logic [3:0] pix_b,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] err_count
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] H_A0   = 10'(H_ACT_START);
    localparam logic [9:0] H_A1   = 10'(H_ACT_END);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SW   = 10'(V_SYNC);
    localparam logic [9:0] V_A0   = 10'(V_ACT_START);
    localparam logic [9:0] V_A1   = 10'(V_ACT_END);
    localparam logic [9:0] H_MAX  = 10'd1023;

    logic      h_rise, h_fall, v_rise, v_fall;
    logic [9:0] hcount, vcount, hc_nxt, vc_nxt;
    logic      timeout, mismatch, active;
    rx_state_e state, state_nxt;

    sync_edge_det u_hsync_edge (.clk(pixClock), .rst(reset), .sig(HSync), .rise(h_rise), .fall(h_fall));
    sync_edge_det u_vsync_edge (.clk(pixClock), .rst(reset), .sig(VSync), .rise(v_rise), .fall(v_fall));

    // Counts for the current sample feed both the counter registers and the outputs,
    // so every output lands exactly one cycle after its input sample.
    always_comb begin
        hc_nxt = hcount + 10'd1;
        if (h_fall)               hc_nxt = '0;
        else if (hcount == H_MAX) hc_nxt = H_MAX;
        vc_nxt = vcount;
        if (h_fall) vc_nxt = v_fall ? '0 : vcount + 10'd1;
        timeout  = !h_fall && (hc_nxt == H_MAX);
        mismatch = (h_fall && hcount != H_LAST)
                || (h_rise && hc_nxt != H_SW)
                || (v_fall && !h_fall)
                || (v_fall && vcount != V_LAST)
                || (v_rise && !(h_fall && vc_nxt == V_SW))
                || timeout;
    end

    // The exiting VSync fall of CHECK is itself checked before LOCKED is granted.
    always_comb begin
        state_nxt = state;
        case (state)
            SEARCH:  if (v_fall) state_nxt = CHECK;
            CHECK:   if (mismatch) state_nxt = SEARCH;
                     else if (v_fall) state_nxt = LOCKED;
            LOCKED:  if (mismatch) state_nxt = SEARCH;
            default: state_nxt = SEARCH;
        endcase
        active = (state_nxt == LOCKED)
              && (hc_nxt >= H_A0) && (hc_nxt <= H_A1)
              && (vc_nxt >= V_A0) && (vc_nxt <= V_A1);
    end

    always_ff @(posedge pixClock or posedge reset) begin
        if (reset) state <= SEARCH;
        else       state <= state_nxt;
    end

    always_ff @(posedge pixClock or posedge reset) begin
        if (reset) begin
            hcount      <= '0;
            vcount      <= '0;
            err_count   <= '0;
            locked      <= 1'b0;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            pix_r       <= '0;
            pix_g       <= '0;
            pix_b       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= hc_nxt;
            vcount      <= vc_nxt;
            locked      <= (state_nxt == LOCKED);
            de          <= active;
            x           <= active ? hc_nxt - H_A0 : '0;
            y           <= active ? 9'(vc_nxt - V_A0) : '0;
            pix_r       <= active ? red   : '0;
            pix_g       <= active ? green : '0;
            pix_b       <= active ? blue  : '0;
            line_start  <= h_fall;
            frame_start <= v_fall;
            if (state == LOCKED && mismatch && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a scaled-down raster: a frame-level source model predicts
// lock, error count, strobes and coordinates for every sample from raster position.
module tb_vga_timing_rx;

    localparam int H_T = 40, H_S = 6, HA0 = 10, HA1 = 35;
    localparam int V_T = 20, V_S = 2, VA0 = 4, VA1 = 17;
    localparam int TIMEOUT_IDX = 1023 - H_T;

    logic       pixClock = 1'b0;
    logic       reset, HSync, VSync;
    logic [3:0] red, green, blue;
    logic       locked, de, line_start, frame_start;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] pix_r, pix_g, pix_b;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;
    bit m_lock;
    int m_acq;
    int m_err;
    bit pend_bad;

    vga_timing_rx #(
        .H_TOTAL(H_T), .H_SYNC(H_S), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(V_T), .V_SYNC(V_S), .V_ACT_START(VA0), .V_ACT_END(VA1)
    ) dut (
        .pixClock(pixClock), .reset(reset), .HSync(HSync), .VSync(VSync),
        .red(red), .green(green), .blue(blue),
        .locked(locked), .de(de), .x(x), .y(y),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .line_start(line_start), .frame_start(frame_start), .err_count(err_count)
    );

    always #5 pixClock = ~pixClock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int gh, input int gv);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (line %0d col %0d)", tag, obs, exp, gv, gh);
        end
    endtask

    // One source sample at raster position (gh,gv); stall = HSync/VSync held high.
    task automatic sample(input int gh, input int gv, input bit stall, input int sidx, input bit rst_now);
        bit fh, fv, bad, e_de;
        logic [3:0] r, g, b;
        fh = !stall && !rst_now && gh == 0;
        fv = fh && gv == 0;
        r = 4'($urandom_range(0, 15));
        g = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        if (gh == HA0 && gv == VA0) r = 4'hF;
        HSync = stall || gh >= H_S;
        VSync = stall || gv >= V_S;
        red = r; green = g; blue = b;
        reset = rst_now;
        if (rst_now) begin
            m_lock = 0; m_acq = 0; m_err = 0; pend_bad = 0;
        end else begin
            bad = (stall && sidx == TIMEOUT_IDX) || (fh && pend_bad);
            if (fh) pend_bad = 0;
            if (bad) begin
                if (m_lock && m_err < 255) m_err++;
                m_lock = 0;
                m_acq  = 0;
            end else if (fv) begin
                m_acq++;
                if (m_acq >= 2) m_lock = 1;
            end
        end
        e_de = !rst_now && m_lock && !stall && gh >= HA0 && gh <= HA1 && gv >= VA0 && gv <= VA1;
        @(posedge pixClock);
        #1;
        chk("locked", 32'(locked), 32'(m_lock), gh, gv);
        chk("de", 32'(de), 32'(e_de), gh, gv);
        chk("x", 32'(x), e_de ? 32'(gh - HA0) : 32'd0, gh, gv);
        chk("y", 32'(y), e_de ? 32'(gv - VA0) : 32'd0, gh, gv);
        chk("pix_r", 32'(pix_r), e_de ? 32'(r) : 32'd0, gh, gv);
        chk("pix_g", 32'(pix_g), e_de ? 32'(g) : 32'd0, gh, gv);
        chk("pix_b", 32'(pix_b), e_de ? 32'(b) : 32'd0, gh, gv);
        chk("line_start", 32'(line_start), 32'(fh), gh, gv);
        chk("frame_start", 32'(frame_start), 32'(fv), gh, gv);
        chk("err_count", 32'(err_count), 32'(m_err), gh, gv);
    endtask

    // A frame of `lines` lines; optional short line, 1100-clock HSync stall before a line,
    // and a 3-clock reset pulse inside a line.
    task automatic run_frame(input int lines, input int short_l, input int stall_l,
                             input int rst_l, input int rst_h);
        for (int v = 0; v < lines; v++) begin
            if (v == stall_l)
                for (int i = 0; i < 1100; i++) sample(0, v, 1'b1, i, 1'b0);
            for (int h = 0; h < ((v == short_l) ? H_T - 1 : H_T); h++)
                sample(h, v, 1'b0, 0, (v == rst_l && h >= rst_h && h < rst_h + 3));
            if (v == short_l) pend_bad = 1;
        end
        if (lines != V_T) pend_bad = 1;
    endtask

    initial begin
        reset = 1'b1; HSync = 1'b1; VSync = 1'b1;
        red = '0; green = '0; blue = '0;
        m_lock = 0; m_acq = 0; m_err = 0; pend_bad = 0;

        for (int i = 0; i < 3; i++) sample(0, 0, 1'b1, 0, 1'b1);

        // Acquire: lock at the second frame start, then a fully locked frame.
        run_frame(V_T, -1, -1, -1, 0);
        run_frame(V_T, -1, -1, -1, 0);
        run_frame(V_T, -1, -1, -1, 0);

        // Shortened line while locked.
        run_frame(V_T, $urandom_range(3, V_T - 2), -1, -1, 0);

        // Short frame while in CHECK, then reacquire.
        run_frame(V_T - 1, -1, -1, -1, 0);
        run_frame(V_T, -1, -1, -1, 0);
        run_frame(V_T, -1, -1, -1, 0);

        // HSync stall while locked.
        run_frame(V_T, -1, $urandom_range(3, V_T - 1), -1, 0);
        run_frame(V_T, -1, -1, -1, 0);

        // Reset mid-active-line while locked, then reacquire.
        run_frame(V_T, -1, -1, $urandom_range(VA0, VA1), $urandom_range(HA0, HA1 - 3));
        run_frame(V_T, -1, -1, -1, 0);
        run_frame(V_T, -1, -1, -1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
